// File: rtl/otbn_pq_bf_sequencer_if.sv
// Command and lane-issue bundle between the PQ decoder, the butterfly sequencer
// and the PQ ALU / WDR write port.
interface otbn_pq_bf_sequencer_if #(
   parameter int NumLanes = 8,
   parameter int TwAddrW  = 8
);
   localparam int LaneW = $clog2(NumLanes);

   // Handshake: start_i is a one-cycle request taken only in IDLE; each cycle
   // with valid_o=1 presents one lane op, which is consumed when stall_i=0
   // (wr_en_o=1). done_o / err_o are single-cycle status pulses.
   logic               start_i;
   logic [7:0]         op_i;
   logic [TwAddrW-1:0] tw_base_i;
   logic [TwAddrW-1:0] tw_inc_i;
   logic               stall_i;
   logic               clear_i;
   logic               busy_o;
   logic               valid_o;
   logic [7:0]         op_o;
   logic [LaneW-1:0]   lane_o;
   logic [TwAddrW-1:0] tw_idx_o;
   logic               wr_en_o;
   logic               add_op_en_o;
   logic               mul_op_en_o;
   logic               gs_sub_op_en_o;
   logic               ct_sub_op_en_o;
   logic               done_o;
   logic               err_o;
   logic [1:0]         state_dbg_o;

   modport master (
      output start_i, op_i, tw_base_i, tw_inc_i, stall_i, clear_i,
      input  busy_o, valid_o, op_o, lane_o, tw_idx_o, wr_en_o,
             add_op_en_o, mul_op_en_o, gs_sub_op_en_o, ct_sub_op_en_o,
             done_o, err_o, state_dbg_o
   );

   modport slave (
      input  start_i, op_i, tw_base_i, tw_inc_i, stall_i, clear_i,
      output busy_o, valid_o, op_o, lane_o, tw_idx_o, wr_en_o,
             add_op_en_o, mul_op_en_o, gs_sub_op_en_o, ct_sub_op_en_o,
             done_o, err_o, state_dbg_o
   );
endinterface

// File: rtl/otbn_pq_bf_sequencer.sv
// Expands one PQ vector command into NumLanes lane operations for otbn_pq_alu,
// generating lane selects, twiddle indices and predecoded blanker enables.
module otbn_pq_bf_sequencer #(
   parameter int NumLanes = 8,
   parameter int TwAddrW  = 8
) (
   input logic                  clk_i,
   input logic                  rst_i,
   otbn_pq_bf_sequencer_if.slave bus
);
   localparam int LaneW = $clog2(NumLanes);
   localparam logic [LaneW-1:0] LastLane = LaneW'(NumLanes - 1);

   localparam logic [7:0] AluOpPqNone        = 8'h00;
   localparam logic [7:0] AluOpPqAdd         = 8'h01;
   localparam logic [7:0] AluOpPqSub         = 8'h02;
   localparam logic [7:0] AluOpPqMul         = 8'h03;
   localparam logic [7:0] AluOpPqScale       = 8'h04;
   localparam logic [7:0] AluOpPqButterflyCT = 8'h05;
   localparam logic [7:0] AluOpPqButterflyGS = 8'h06;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDone  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         op_q, op_d;
   logic [LaneW-1:0]   lane_q, lane_d;
   logic [TwAddrW-1:0] tw_idx_q, tw_idx_d;
   logic [TwAddrW-1:0] tw_inc_q, tw_inc_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [3:0]         en_q, en_d;  // {add, mul, gs_sub, ct_sub}

   function automatic logic op_supported(input logic [7:0] op);
      case (op)
         AluOpPqAdd, AluOpPqSub, AluOpPqMul, AluOpPqScale,
         AluOpPqButterflyCT, AluOpPqButterflyGS: op_supported = 1'b1;
         default:                                op_supported = 1'b0;
      endcase
   endfunction

   // Must match the enable set the ALU expects for each op, otherwise its
   // predecode cross-check raises alu_predec_error_o.
   function automatic logic [3:0] predecode(input logic [7:0] op);
      case (op)
         AluOpPqAdd:         predecode = 4'b1000;
         AluOpPqSub:         predecode = 4'b0001;
         AluOpPqMul,
         AluOpPqScale:       predecode = 4'b0100;
         AluOpPqButterflyCT: predecode = 4'b1101;
         AluOpPqButterflyGS: predecode = 4'b1110;
         default:            predecode = 4'b0000;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      lane_d   = lane_q;
      tw_idx_d = tw_idx_q;
      tw_inc_d = tw_inc_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      en_d     = en_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      if (bus.clear_i) begin
         state_d  = StIdle;
         op_d     = AluOpPqNone;
         lane_d   = '0;
         tw_idx_d = '0;
         valid_d  = 1'b0;
         busy_d   = 1'b0;
         en_d     = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start_i) begin
                  if (op_supported(bus.op_i)) begin
                     state_d  = StIssue;
                     op_d     = bus.op_i;
                     lane_d   = '0;
                     tw_idx_d = bus.tw_base_i;
                     tw_inc_d = bus.tw_inc_i;
                     valid_d  = 1'b1;
                     busy_d   = 1'b1;
                     en_d     = predecode(bus.op_i);
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StIssue: begin
               err_d = bus.start_i;
               if (!bus.stall_i) begin
                  if (lane_q == LastLane) begin
                     state_d  = StDone;
                     op_d     = AluOpPqNone;
                     lane_d   = '0;
                     tw_idx_d = '0;
                     valid_d  = 1'b0;
                     en_d     = '0;
                     done_d   = 1'b1;
                  end else begin
                     lane_d   = lane_q + 1'b1;
                     tw_idx_d = tw_idx_q + tw_inc_q;
                  end
               end
            end
            StDone: begin
               err_d   = bus.start_i;
               state_d = StIdle;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = StIdle;
               op_d    = AluOpPqNone;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               en_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         op_q     <= AluOpPqNone;
         lane_q   <= '0;
         tw_idx_q <= '0;
         tw_inc_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         en_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         lane_q   <= lane_d;
         tw_idx_q <= tw_idx_d;
         tw_inc_q <= tw_inc_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         en_q     <= en_d;
      end
   end

   assign bus.busy_o         = busy_q;
   assign bus.valid_o        = valid_q;
   assign bus.op_o           = op_q;
   assign bus.lane_o         = lane_q;
   assign bus.tw_idx_o       = tw_idx_q;
   // The write strobe must drop in the same cycle the WDR port reports busy.
   assign bus.wr_en_o        = valid_q & ~bus.stall_i;
   assign bus.add_op_en_o    = en_q[3];
   assign bus.mul_op_en_o    = en_q[2];
   assign bus.gs_sub_op_en_o = en_q[1];
   assign bus.ct_sub_op_en_o = en_q[0];
   assign bus.done_o         = done_q;
   assign bus.err_o          = err_q;
   assign bus.state_dbg_o    = state_q;
endmodule

// File: tb/tb_otbn_pq_bf_sequencer.sv
// Directed bench for otbn_pq_bf_sequencer: lane/twiddle sequencing, stalls,
// error pulses, clear and asynchronous reset.
module tb_otbn_pq_bf_sequencer;
   localparam logic [7:0] OP_NONE  = 8'h00;
   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h02;
   localparam logic [7:0] OP_MUL   = 8'h03;
   localparam logic [7:0] OP_SCALE = 8'h04;
   localparam logic [7:0] OP_CT    = 8'h05;
   localparam logic [7:0] OP_GS    = 8'h06;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   logic [3:0] en_obs;

   otbn_pq_bf_sequencer_if #(.NumLanes(8), .TwAddrW(8)) bus ();

   otbn_pq_bf_sequencer #(.NumLanes(8), .TwAddrW(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   assign en_obs = {bus.add_op_en_o, bus.mul_op_en_o, bus.gs_sub_op_en_o, bus.ct_sub_op_en_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_cmp++;
      if ({bus.busy_o, bus.valid_o, bus.wr_en_o, bus.done_o, bus.err_o} !== 5'b0 ||
          bus.op_o !== OP_NONE || bus.lane_o !== 3'd0 || bus.tw_idx_o !== 8'h00 ||
          en_obs !== 4'b0000 || bus.state_dbg_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset: busy=%b valid=%b wr=%b done=%b err=%b op=%h lane=%0d tw=%h en=%b st=%0d required all zero",
                  bus.busy_o, bus.valid_o, bus.wr_en_o, bus.done_o, bus.err_o, bus.op_o,
                  bus.lane_o, bus.tw_idx_o, en_obs, bus.state_dbg_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ct();
      logic [7:0] exp_tw;
      int wr_cnt;
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_CT; bus.tw_base_i = 8'h10; bus.tw_inc_i = 8'h02;
      exp_tw = 8'h10;
      wr_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         #1;
         n_cmp++;
         if (bus.lane_o !== 3'(k) || bus.tw_idx_o !== exp_tw || bus.valid_o !== 1'b1 ||
             en_obs !== 4'b1101 || bus.done_o !== 1'b0 || bus.op_o !== OP_CT || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ct_lane%0d: lane=%0d tw=%h valid=%b en=%b done=%b op=%h err=%b required lane=%0d tw=%h valid=1 en=1101 done=0 op=%h err=0",
                     k, bus.lane_o, bus.tw_idx_o, bus.valid_o, en_obs, bus.done_o, bus.op_o, bus.err_o,
                     k, exp_tw, OP_CT);
         end
         if (bus.wr_en_o === 1'b1) wr_cnt++;
         exp_tw = exp_tw + 8'h02;
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.done_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1 ||
          en_obs !== 4'b0000 || bus.wr_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ct_done: done=%b valid=%b busy=%b en=%b wr=%b required done=1 valid=0 busy=1 en=0000 wr=0",
                  bus.done_o, bus.valid_o, bus.busy_o, en_obs, bus.wr_en_o);
      end
      n_cmp++;
      if (wr_cnt !== 8) begin
         n_fail++;
         $display("FAIL ct_wr_count: got %0d required 8", wr_cnt);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ct_idle: busy=%b done=%b required 0 0", bus.busy_o, bus.done_o);
      end
   endtask

   task automatic test_gs_wrap();
      logic [7:0] exp_tw;
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_GS; bus.tw_base_i = 8'hFC; bus.tw_inc_i = 8'h02;
      exp_tw = 8'hFC;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         #1;
         n_cmp++;
         if (bus.lane_o !== 3'(k) || bus.tw_idx_o !== exp_tw || en_obs !== 4'b1110 || bus.wr_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL gs_lane%0d: lane=%0d tw=%h en=%b wr=%b required lane=%0d tw=%h en=1110 wr=1",
                     k, bus.lane_o, bus.tw_idx_o, en_obs, bus.wr_en_o, k, exp_tw);
         end
         exp_tw = exp_tw + 8'h02;
      end
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL gs_idle: busy=%b required 0", bus.busy_o);
      end
   endtask

   task automatic test_stall();
      logic [2:0] exp_lane;
      logic [7:0] exp_tw;
      int stall_cnt;
      int wr_cnt;
      int cyc;
      logic stall;
      logic finished;
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_ADD; bus.tw_base_i = 8'h40; bus.tw_inc_i = 8'h01;
      exp_lane = 3'd0; exp_tw = 8'h40; stall_cnt = 0; wr_cnt = 0; finished = 1'b0;
      for (cyc = 1; cyc <= 14 && !finished; cyc++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         stall = (exp_lane == 3'd3 && stall_cnt < 2);
         bus.stall_i = stall;
         #1;
         if (exp_lane == 3'd7 && cyc == 11) begin
            finished = 1'b1;
         end
         n_cmp++;
         if (bus.lane_o !== exp_lane || bus.tw_idx_o !== exp_tw || bus.valid_o !== 1'b1 ||
             bus.wr_en_o !== ~stall || en_obs !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_cyc%0d: lane=%0d tw=%h valid=%b wr=%b en=%b required lane=%0d tw=%h valid=1 wr=%b en=1000",
                     cyc, bus.lane_o, bus.tw_idx_o, bus.valid_o, bus.wr_en_o, en_obs, exp_lane, exp_tw, ~stall);
         end
         if (bus.wr_en_o === 1'b1) wr_cnt++;
         if (stall) begin
            stall_cnt++;
         end else if (exp_lane == 3'd7) begin
            finished = 1'b1;
         end else begin
            exp_lane = exp_lane + 3'd1;
            exp_tw = exp_tw + 8'h01;
         end
      end
      bus.stall_i = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.done_o !== 1'b1 || cyc !== 11) begin
         n_fail++;
         $display("FAIL stall_done: done=%b at cycle %0d required done=1 at cycle 11", bus.done_o, cyc);
      end
      n_cmp++;
      if (wr_cnt !== 8) begin
         n_fail++;
         $display("FAIL stall_wr_count: got %0d required 8", wr_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_errors();
      int wr_cnt;
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = 8'hFF; bus.tw_base_i = 8'h00; bus.tw_inc_i = 8'h01;
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      n_cmp++;
      if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_invalid: err=%b busy=%b valid=%b required err=1 busy=0 valid=0",
                  bus.err_o, bus.busy_o, bus.valid_o);
      end
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_MUL; bus.tw_base_i = 8'h00; bus.tw_inc_i = 8'h01;
      #1;
      n_cmp++;
      if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_single_pulse: err=%b busy=%b required err=0 busy=0", bus.err_o, bus.busy_o);
      end
      wr_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.start_i = (k == 1);
         bus.op_i = (k == 1) ? OP_ADD : OP_MUL;
         #1;
         n_cmp++;
         if (bus.lane_o !== 3'(k) || bus.tw_idx_o !== 8'(k) || bus.op_o !== OP_MUL ||
             en_obs !== 4'b0100 || bus.err_o !== (k == 2)) begin
            n_fail++;
            $display("FAIL mul_lane%0d: lane=%0d tw=%h op=%h en=%b err=%b required lane=%0d tw=%h op=%h en=0100 err=%b",
                     k, bus.lane_o, bus.tw_idx_o, bus.op_o, en_obs, bus.err_o, k, 8'(k), OP_MUL, (k == 2));
         end
         if (bus.wr_en_o === 1'b1) wr_cnt++;
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.done_o !== 1'b1 || wr_cnt !== 8) begin
         n_fail++;
         $display("FAIL mul_done: done=%b wr_count=%0d required done=1 wr_count=8", bus.done_o, wr_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_clear();
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_SCALE; bus.tw_base_i = 8'h00; bus.tw_inc_i = 8'h01;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         bus.clear_i = (k == 5);
         #1;
         n_cmp++;
         if (bus.lane_o !== 3'(k) || en_obs !== 4'b0100 || bus.valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL scale_lane%0d: lane=%0d en=%b valid=%b required lane=%0d en=0100 valid=1",
                     k, bus.lane_o, en_obs, bus.valid_o, k);
         end
      end
      @(negedge clk);
      bus.clear_i = 1'b0;
      #1;
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.wr_en_o !== 1'b0 ||
          en_obs !== 4'b0000 || bus.done_o !== 1'b0 || bus.op_o !== OP_NONE) begin
         n_fail++;
         $display("FAIL clear: busy=%b valid=%b wr=%b en=%b done=%b op=%h required all zero",
                  bus.busy_o, bus.valid_o, bus.wr_en_o, en_obs, bus.done_o, bus.op_o);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_no_done: done=%b busy=%b required 0 0", bus.done_o, bus.busy_o);
      end
      bus.start_i = 1'b1; bus.op_i = OP_ADD; bus.tw_base_i = 8'h20; bus.tw_inc_i = 8'h01;
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      n_cmp++;
      if (bus.lane_o !== 3'd0 || bus.tw_idx_o !== 8'h20 || bus.valid_o !== 1'b1 || en_obs !== 4'b1000) begin
         n_fail++;
         $display("FAIL clear_restart: lane=%0d tw=%h valid=%b en=%b required lane=0 tw=20 valid=1 en=1000",
                  bus.lane_o, bus.tw_idx_o, bus.valid_o, en_obs);
      end
      repeat (8) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_restart_done: done=%b required 1", bus.done_o);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = OP_SUB; bus.tw_base_i = 8'h08; bus.tw_inc_i = 8'h04;
      repeat (3) begin
         @(negedge clk);
         bus.start_i = 1'b0;
      end
      #1;
      n_cmp++;
      if (bus.lane_o !== 3'd2 || bus.tw_idx_o !== 8'h10 || en_obs !== 4'b0001) begin
         n_fail++;
         $display("FAIL sub_lane2: lane=%0d tw=%h en=%b required lane=2 tw=10 en=0001",
                  bus.lane_o, bus.tw_idx_o, en_obs);
      end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.busy_o, bus.valid_o, bus.wr_en_o, bus.done_o} !== 4'b0 || bus.lane_o !== 3'd0 ||
          bus.tw_idx_o !== 8'h00 || en_obs !== 4'b0000 || bus.op_o !== OP_NONE) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b valid=%b wr=%b done=%b lane=%0d tw=%h en=%b op=%h required all zero",
                  bus.busy_o, bus.valid_o, bus.wr_en_o, bus.done_o, bus.lane_o, bus.tw_idx_o, en_obs, bus.op_o);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (bus.wr_en_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset%0d: wr=%b done=%b busy=%b required 0 0 0",
                     k, bus.wr_en_o, bus.done_o, bus.busy_o);
         end
      end
      bus.start_i = 1'b1; bus.op_i = OP_CT; bus.tw_base_i = 8'h00; bus.tw_inc_i = 8'h01;
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      n_cmp++;
      if (bus.lane_o !== 3'd0 || bus.valid_o !== 1'b1 || en_obs !== 4'b1101) begin
         n_fail++;
         $display("FAIL post_reset_start: lane=%0d valid=%b en=%b required lane=0 valid=1 en=1101",
                  bus.lane_o, bus.valid_o, en_obs);
      end
      repeat (9) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      bus.start_i = 1'b0;
      bus.op_i = OP_NONE;
      bus.tw_base_i = 8'h00;
      bus.tw_inc_i = 8'h00;
      bus.stall_i = 1'b0;
      bus.clear_i = 1'b0;
      test_reset();
      test_ct();
      test_gs_wrap();
      test_stall();
      test_errors();
      test_clear();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/otbn_pq_bf_sequencer.md
Name: otbn_pq_bf_sequencer

Overview:
- Issues one PQ ALU operation per cycle across the 32-bit lanes of a 256-bit WDR pair, starting from a single command.
- Drives the word selects, twiddle index and predecoded blanking enables consumed by otbn_pq_alu.
- Sits between the PQ instruction decoder and the ALU/WDR write port.
- Turns one vector instruction (add, sub, mul, scale, CT or GS butterfly) into a counted sequence of lane operations with stall, abort and error handling.

Parameters:
- NumLanes, 8, lanes per WDR (PQLEN*NumLanes = 256); lane index width LaneW = $clog2(NumLanes).
- TwAddrW, 8, width of the twiddle-ROM index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  command request, sampled in IDLE only
- op_i  in  8  alu op code (otbn_pq_pkg AluOpPq* encoding)
- tw_base_i  in  TwAddrW  first twiddle index
- tw_inc_i  in  TwAddrW  twiddle index step per lane
- stall_i  in  1  hold current lane (WDR port busy)
- clear_i  in  1  synchronous abort
- busy_o  out  1  sequence in progress
- valid_o  out  1  current lane op is valid
- op_o  out  8  op presented to the ALU
- lane_o  out  LaneW  drives operand_a_w_sel, operand_b_w_sel and d_w_sel
- tw_idx_o  out  TwAddrW  twiddle ROM index
- wr_en_o  out  1  WDR write strobe for lane_o
- add_op_en_o, mul_op_en_o, gs_sub_op_en_o, ct_sub_op_en_o  out  1 each  predecode/blanker enables
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse

Behaviour:
- Output registers and reset:
  - All outputs are registered.
  - Reset (async, rst_i=1) forces state IDLE and every output to 0, including op_o = AluOpPqNone.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - start_i=1 with a supported op (Add, Sub, Mul, Scale, ButterflyCT, ButterflyGS) latches op_i, tw_base_i and tw_inc_i.
  - It then moves to ISSUE, so the first valid_o appears the cycle after start_i.
  - start_i=1 with any other op (including None) pulses err_o for one cycle and stays in IDLE.
- ISSUE:
  - busy_o=1 and valid_o=1.
  - lane_o starts at 0. tw_idx_o starts at tw_base and wraps modulo 2^TwAddrW.
  - wr_en_o = valid_o & ~stall_i, combinationally gated from the registered valid.
  - stall_i=1 holds lane_o, tw_idx_o and all enables unchanged.
  - stall_i=0 advances lane_o by 1 and tw_idx_o by tw_inc.
  - On the last lane (NumLanes-1) with stall_i=0, the FSM moves to DONE.
- DONE:
  - done_o=1, busy_o=1, valid_o=0, all enables 0.
  - Next cycle returns to IDLE.
- Predecode enables, asserted only while valid_o=1, else 0 (keeps blankers closed):
  - Add: add.
  - Sub: ct_sub.
  - Mul and Scale: mul.
  - ButterflyCT: add, mul, ct_sub.
  - ButterflyGS: add, mul, gs_sub.
  - These enables must always equal the ALU's expected set, so alu_predec_error_o stays 0.
- start_i while busy_o=1 pulses err_o for one cycle; the sequence in progress is unaffected.
- clear_i=1 in any state returns to IDLE next cycle:
  - valid_o, wr_en_o and all enables are 0 from that edge.
  - No done_o pulse is produced.
  - clear_i takes priority over start_i and stall_i.
- Reset mid-sequence: immediate return to the reset values. No partial done_o or wr_en_o pulse after reset is released.
- Latency: NumLanes + 1 cycles from the start_i edge to done_o, with no stalls.

Test Plan:
- ButterflyCT, tw_base=0x10, tw_inc=0x02, no stalls:
  - lane_o 0..7 on consecutive cycles; tw_idx_o 0x10,0x12..0x1E.
  - add, mul and ct_sub enables =1 on all 8 cycles; done_o in cycle 9; 8 wr_en_o pulses.
- ButterflyGS, tw_base=0xFC, tw_inc=0x02:
  - tw_idx_o sequence is 0xFC,0xFE,0x00,0x02.. (wrap-around).
  - gs_sub enable =1 and ct_sub enable =0 throughout.
- Add with stall_i=1 at lane 3 for 2 cycles:
  - lane_o holds at 3 for 3 cycles with wr_en_o=0 during the stall.
  - Exactly 8 wr_en_o pulses total; done_o at cycle 11.
- Invalid op 0xFF, then start_i during a running Mul:
  - err_o pulses each time and busy_o stays 0 for the invalid op.
  - The Mul completes its 8 lanes unchanged.
- clear_i at lane 5 of a Scale:
  - Next cycle busy_o=0, valid_o=0 and all enables 0; no done_o.
  - A new start then begins again at lane 0.
- rst_i asserted asynchronously mid-ISSUE:
  - Outputs go to 0 without waiting for a clock edge.
  - After release the FSM is in IDLE and accepts a new start.
